// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared widths, default thresholds and pointer type for sync_fifo.
package sync_fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_AEMPTY_TH = 2;
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction
  function automatic int def_afull_th(input int addr_w);
    return (1 << addr_w) - 2;
  endfunction
  typedef logic [DEF_ADDR_W:0] ptr_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, one write port and one registered read port, no reset.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_W];
  // Read-before-write: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flags, count and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through mode.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AFULL_TH = def_afull_th(ADDR_W),
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(ADDR_W)-1:0] count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int CW = cnt_w(ADDR_W);
  typedef logic [CW-1:0] cnt_t;
  cnt_t wr_ptr, rd_ptr;
  logic ram_empty, ram_rd, wr_acc, rd_rej, dv_nxt, have_data;
  logic [WIDTH-1:0] rdata;
  always_comb begin
    ram_empty = wr_ptr == rd_ptr;
    full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    count = wr_ptr - rd_ptr;
    almost_full = count >= CW'(AFULL_TH);
    almost_empty = count <= CW'(AEMPTY_TH);
`ifdef SYNC_FIFO_FWFT_EN
    // The output register refills from RAM whenever it is empty or being popped.
    ram_rd = !ram_empty && (!dout_valid || rd_en);
    rd_rej = rd_en && !dout_valid;
    dv_nxt = ram_rd || (dout_valid && !rd_en);
    empty = !dout_valid;
`else
    ram_rd = rd_en && !ram_empty;
    rd_rej = rd_en && ram_empty;
    dv_nxt = ram_rd;
    empty = ram_empty;
`endif
    wr_acc = wr_en && (!full || ram_rd);
    dout = have_data ? rdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout_valid <= 1'b0;
      have_data <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + cnt_t'(1);
      if (ram_rd) rd_ptr <= rd_ptr + cnt_t'(1);
      if (ram_rd) have_data <= 1'b1;
      dout_valid <= dv_nxt;
      overflow <= wr_en && !wr_acc;
      underflow <= rd_rej;
    end
  end
  fifo_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(wr_acc),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(din),
    .re(ram_rd),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (ADDR_W=2, depth 4).
module tb_sync_fifo;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0, dout;
  logic dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sync_fifo #(.WIDTH(8), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .dout_valid(dout_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    din = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dv"}, dout_valid, 0);
    chk({tag, "_aempty"}, almost_empty, 1);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
  endtask
  initial begin
    step(0, 0, 0);
    step(0, 0, 0);
    chk_reset("rst");
    rst = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    step(1, 0, 8'h77);
    chk("fw_dv_n", dout_valid, 0);
    chk("fw_empty_n", empty, 1);
    step(0, 0, 0);
    chk("fw_dv_n1", dout_valid, 1);
    chk("fw_dout_n1", dout, 8'h77);
    chk("fw_empty_n1", empty, 0);
    chk("fw_count_n1", count, 0);
    step(0, 1, 0);
    chk("fw_dv_pop", dout_valid, 0);
    chk("fw_empty_pop", empty, 1);
    step(0, 1, 0);
    chk("fw_unf", underflow, 1);
`else
    step(1, 0, 8'h11);
    chk("t1_count1", count, 1);
    step(1, 0, 8'h22);
    chk("t1_count2", count, 2);
    step(1, 0, 8'h33);
    chk("t1_count3", count, 3);
    chk("t1_afull", almost_full, 1);
    chk("t1_aempty", almost_empty, 0);
    step(0, 1, 0);
    chk("t1_pop1", dout, 8'h11);
    chk("t1_dv1", dout_valid, 1);
    chk("t1_cnt_p1", count, 2);
    step(0, 1, 0);
    chk("t1_pop2", dout, 8'h22);
    chk("t1_cnt_p2", count, 1);
    chk("t1_aempty1", almost_empty, 1);
    step(0, 1, 0);
    chk("t1_pop3", dout, 8'h33);
    chk("t1_cnt_p3", count, 0);
    chk("t1_empty", empty, 1);
    step(0, 0, 0);
    chk("t1_dv_off", dout_valid, 0);
    chk("t1_hold", dout, 8'h33);
    for (int i = 0; i < 4; i++) step(1, 0, 8'hA0 + 8'(i));
    chk("t2_full", full, 1);
    chk("t2_count4", count, 4);
    chk("t2_noovf", overflow, 0);
    step(1, 0, 8'hA4);
    chk("t2_ovf", overflow, 1);
    chk("t2_count_ovf", count, 4);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'hB0 + 8'(i));
      chk("t3_count", count, 4);
      chk("t3_full", full, 1);
      chk("t3_ovf", overflow, 0);
      chk("t3_dout", dout, 8'hA0 + 8'(i));
    end
    step(0, 1, 0);
    chk("t3_wrap0", dout, 8'hA3);
    chk("t3_full_off", full, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("t3_wrap", dout, 8'hB0 + 8'(i));
    end
    chk("t3_empty", empty, 1);
    step(1, 1, 8'h5A);
    chk("t4_unf", underflow, 1);
    chk("t4_count", count, 1);
    chk("t4_dv", dout_valid, 0);
    step(0, 1, 0);
    chk("t4_dout", dout, 8'h5A);
    chk("t4_dv2", dout_valid, 1);
    chk("t4_unf_off", underflow, 0);
    for (int i = 1; i <= 3; i++) step(1, 0, 8'(i));
    step(0, 0, 0);
    chk("t5_count_pre", count, 3);
    #3 rst = 1'b1;
    #1 chk_reset("t5_async");
    #1 rst = 1'b0;
    step(0, 1, 0);
    chk("t5_unf", underflow, 1);
    chk("t5_dv", dout_valid, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Parametrised single-clock FIFO. Storage is a simple dual-port RAM: one write port and one registered read port.
- Successor to the team's fixed 8-bit × 256 dual-port RAM. Adds pointer management, full/empty/almost flags, occupancy count, error pulses and reset.
- Used as the standard elastic buffer between byte/word producers and consumers in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- ADDR_W, 8, address bits; RAM depth = 2**ADDR_W (≥2).
- AFULL_TH, 2**ADDR_W-2, almost_full asserted when count ≥ AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserted when count ≤ AEMPTY_TH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-high.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- dout  out  WIDTH  read data.
- dout_valid  out  1  dout holds a freshly popped / head word.
- full  out  1  RAM holds 2**ADDR_W words.
- empty  out  1  no word available to pop.
- almost_full  out  1  count ≥ AFULL_TH.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- count  out  ADDR_W+1  RAM occupancy, 0..2**ADDR_W.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (async, rst=1): wr_ptr, rd_ptr and count are 0; dout=0; dout_valid=0; empty=1; full=0; almost_empty=1; almost_full=0 (AFULL_TH>0); overflow=0; underflow=0. RAM contents are not reset.
- Pointers are ADDR_W+1 bits. full = MSBs differ and low bits equal; empty (RAM) = pointers equal. count = wr_ptr − rd_ptr, modulo 2**(ADDR_W+1). Pointers wrap naturally past 2**ADDR_W−1 to 0.
- Write accept: wr_en & (!full | rd_accept). The word goes to RAM[wr_ptr] and wr_ptr increments.
- Write rejected (wr_en & !accept): overflow=1 for the next cycle. Pointers and RAM are unchanged.
- Read accept (standard mode): rd_en & !empty. dout ← RAM[rd_ptr] registered at the same edge, so read latency is 1 clock. dout_valid=1 for exactly that following cycle, and rd_ptr increments.
- Read rejected: underflow=1 for the next cycle. dout holds its last value and dout_valid=0.
- Simultaneous accepted read and write: count is unchanged.
- Full + rd_en + wr_en: both are accepted and full stays 1.
- Empty + rd_en + wr_en: write accepted, read rejected (no bypass), underflow pulses, count becomes 1.
- Flags and count are registered and reflect state after the clock edge; no combinational path from wr_en/rd_en to any output.
- Reset mid-operation: all state clears immediately. Pending data is discarded; no partial pops.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - An output register prefetches the head word, so dout shows it with dout_valid=1 before any rd_en; rd_en acknowledges (pops) it.
  - empty = !dout_valid.
  - A word written into an empty FIFO at edge N has dout_valid=1 after edge N+1.
  - The output register is an extra stage: total capacity 2**ADDR_W+1. count and full refer to RAM occupancy only.
  - rd_en while dout_valid=0 raises underflow.
- Undefined: standard 1-cycle registered read as above.

Decomposition:
- Package sync_fifo_pkg holds:
  - a function computing the count width from ADDR_W;
  - default threshold constants;
  - a typedef for the pointer (ADDR_W+1 bits).
- Sub-module fifo_ram: simple dual-port RAM, write port (we, waddr, wdata), registered read port (re, raddr, rdata), no reset. It supersedes the unregistered-read RAM.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles, then 3 pops → dout 0x11,0x22,0x33, each 1 cycle after its rd_en. count steps 3→0. empty=1 at the end.
- ADDR_W=2: write 5 words (0xA0..0xA4) → full=1 after the 4th write. The 5th raises overflow for 1 cycle; count=4. Popping 4 words returns 0xA0..0xA3.
- Full FIFO with rd_en=wr_en=1 for 3 cycles → count stays 4, full stays 1, no overflow. Data order is preserved across pointer wrap.
- Empty FIFO, rd_en=wr_en=1 in the same cycle with din=0x5A → underflow pulse, count=1. A pop next cycle returns 0x5A.
- Assert rst asynchronously between clock edges with count=3 → all outputs return to reset values before the next edge. A subsequent pop raises underflow.
- With SYNC_FIFO_FWFT_EN: write 0x77 into an empty FIFO at edge N → dout=0x77, dout_valid=1 after edge N+1 with no rd_en. rd_en then clears dout_valid.
